// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: schedules the single regfile write port
// between the writeback stage (priority) and the multicycle unit, with a
// starvation guard for the MDU and a pending-write scoreboard for decode.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    // writeback stage request (never back-pressured)
    input  logic        wb_valid,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    // multicycle unit request
    input  logic        mdu_valid,
    output logic        mdu_ready,
    input  logic [4:0]  mdu_addr,
    input  logic [31:0] mdu_data,
    // one-cycle request for WB to stay quiet so a starved MDU can write
    output logic        wb_hold,
    // scoreboard set port and decode hazard check
    input  logic        sb_set,
    input  logic [4:0]  sb_set_addr,
    input  logic [4:0]  chk_addr1,
    input  logic [4:0]  chk_addr2,
    output logic        chk_hazard,
    output logic [31:0] busy,
    // regfile write port (captured by the regfile on the following negedge)
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    // sticky protocol-error flag
    output logic        err
);

    logic             rf_we_q,    rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;
    logic             wb_hold_q,  wb_hold_d;
    logic             err_q,      err_d;
    logic [31:0]      busy_q,     busy_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W:0]   cnt_inc;
    logic             mdu_xfer;

    // Grant and hazard check: WB always wins; MDU is accepted only when WB is idle.
    always_comb begin
        mdu_ready  = mdu_valid && !wb_valid;
        mdu_xfer   = mdu_valid && mdu_ready;
        chk_hazard = busy_q[chk_addr1] | busy_q[chk_addr2];
    end

    // Next-state for write port, starvation counter, error flag and scoreboard.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        wb_hold_d  = 1'b0;
        err_d      = err_q;
        busy_d     = busy_q;
        cnt_d      = '0;
        cnt_inc    = {1'b0, cnt_q} + (CNT_W+1)'(1);

        // Write port: a grant to r0 completes the handshake but never writes.
        if (wb_valid) begin
            rf_we_d    = (wb_addr != 5'd0);
            rf_waddr_d = wb_addr;
            rf_wdata_d = wb_data;
        end else if (mdu_xfer) begin
            rf_we_d    = (mdu_addr != 5'd0);
            rf_waddr_d = mdu_addr;
            rf_wdata_d = mdu_data;
        end

        // Starvation: count refused MDU cycles; on reaching the limit raise
        // wb_hold for the next cycle and restart the count.
        if (mdu_valid && !mdu_ready) begin
            if (cnt_inc == (CNT_W+1)'(STARVE_LIMIT)) begin
                wb_hold_d = 1'b1;
                cnt_d     = '0;
            end else begin
                cnt_d = cnt_inc[CNT_W-1:0];
            end
        end

        // Protocol errors: WB ignoring hold, or WB overwriting a pending MDU target.
        if (wb_valid && (wb_hold_q || busy_q[wb_addr])) begin
            err_d = 1'b1;
        end

        // Scoreboard: clear on MDU completion, then set so a same-cycle set wins.
        if (mdu_xfer) begin
            busy_d[mdu_addr] = 1'b0;
        end
        if (sb_set) begin
            busy_d[sb_set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments in clocked blocks so every flop samples
        // the pre-edge value regardless of statement order.
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            wb_hold_q  <= 1'b0;
            err_q      <= 1'b0;
            // NOTE: the scoreboard is a flop vector, not a RAM, and must be
            // cleared on reset because the MDU loses its in-flight ops too.
            busy_q     <= '0;
            cnt_q      <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            wb_hold_q  <= wb_hold_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
        end
    end

    // Registered outputs.
    always_comb begin
        rf_we    = rf_we_q;
        rf_waddr = rf_waddr_q;
        rf_wdata = rf_wdata_q;
        wb_hold  = wb_hold_q;
        err      = err_q;
        busy     = busy_q;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: per-cycle vectors carry inputs
// plus expected same-cycle and next-cycle outputs; next-cycle expectations go
// through a scoreboard queue and are compared after the following posedge.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        wb_hold;
    logic        sb_set;
    logic [4:0]  sb_set_addr;
    logic [4:0]  chk_addr1;
    logic [4:0]  chk_addr2;
    logic        chk_hazard;
    logic [31:0] busy;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        err;

    int tests_run = 0;
    int tests_failed = 0;

    regfile_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
        .wb_hold(wb_hold),
        .sb_set(sb_set), .sb_set_addr(sb_set_addr),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_hazard(chk_hazard),
        .busy(busy),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        // inputs
        logic        wv;  logic [4:0] wa;  logic [31:0] wd;
        logic        mv;  logic [4:0] ma;  logic [31:0] md;
        logic        ss;  logic [4:0] ssa;
        logic [4:0]  c1;  logic [4:0] c2;
        // same-cycle expectations
        logic        e_rdy; logic e_haz;
        // next-cycle expectations
        logic        e_we;  logic [4:0] e_wa; logic [31:0] e_wd;
        logic        e_hold; logic e_err; logic [31:0] e_busy;
    } vec_t;

    typedef struct {
        logic        we; logic [4:0] wa; logic [31:0] wd;
        logic        hold; logic err; logic [31:0] busy;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic wv, input logic [4:0] wa, input logic [31:0] wd,
        input logic mv, input logic [4:0] ma, input logic [31:0] md,
        input logic ss, input logic [4:0] ssa, input logic [4:0] c1, input logic [4:0] c2,
        input logic e_rdy, input logic e_haz,
        input logic e_we, input logic [4:0] e_wa, input logic [31:0] e_wd,
        input logic e_hold, input logic e_err, input logic [31:0] e_busy);
        vec_t v;
        v.wv = wv; v.wa = wa; v.wd = wd; v.mv = mv; v.ma = ma; v.md = md;
        v.ss = ss; v.ssa = ssa; v.c1 = c1; v.c2 = c2;
        v.e_rdy = e_rdy; v.e_haz = e_haz;
        v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd;
        v.e_hold = e_hold; v.e_err = e_err; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic idle_inputs();
        wb_valid = 0; wb_addr = 0; wb_data = 0;
        mdu_valid = 0; mdu_addr = 0; mdu_data = 0;
        sb_set = 0; sb_set_addr = 0; chk_addr1 = 0; chk_addr2 = 0;
    endtask

    // One cycle: drive, check combinational outputs at negedge, push the
    // registered expectation, then pop and compare just after the posedge.
    task automatic run_vec(input string name, input vec_t v);
        exp_t e;
        exp_t got;
        wb_valid = v.wv; wb_addr = v.wa; wb_data = v.wd;
        mdu_valid = v.mv; mdu_addr = v.ma; mdu_data = v.md;
        sb_set = v.ss; sb_set_addr = v.ssa; chk_addr1 = v.c1; chk_addr2 = v.c2;
        @(negedge clk);
        check({name, ".mdu_ready"}, 32'(mdu_ready), 32'(v.e_rdy));
        check({name, ".chk_hazard"}, 32'(chk_hazard), 32'(v.e_haz));
        e.we = v.e_we; e.wa = v.e_wa; e.wd = v.e_wd;
        e.hold = v.e_hold; e.err = v.e_err; e.busy = v.e_busy;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check({name, ".rf_we"}, 32'(rf_we), 32'(got.we));
        if (got.we) begin
            check({name, ".rf_waddr"}, 32'(rf_waddr), 32'(got.wa));
            check({name, ".rf_wdata"}, rf_wdata, got.wd);
        end
        check({name, ".wb_hold"}, 32'(wb_hold), 32'(got.hold));
        check({name, ".err"}, 32'(err), 32'(got.err));
        check({name, ".busy"}, busy, got.busy);
    endtask

    task automatic do_reset(input string name);
        idle_inputs();
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        check({name, ".rf_we"}, 32'(rf_we), 32'd0);
        check({name, ".rf_waddr"}, 32'(rf_waddr), 32'd0);
        check({name, ".rf_wdata"}, rf_wdata, 32'd0);
        check({name, ".wb_hold"}, 32'(wb_hold), 32'd0);
        check({name, ".err"}, 32'(err), 32'd0);
        check({name, ".busy"}, busy, 32'd0);
        check({name, ".mdu_ready"}, 32'(mdu_ready), 32'd0);
        check({name, ".chk_hazard"}, 32'(chk_hazard), 32'd0);
    endtask

    vec_t tbl[14];

    initial begin
        //              wv wa  wd      mv ma  md            ss ssa c1 c2  rdy haz  we wa  wd            hold err busy
        tbl[0]  = mk(0, 0, 0,      1, 5, 32'hDEADBEEF, 0, 0, 0, 0,  1, 0,  1, 5, 32'hDEADBEEF, 0, 0, 32'h0);
        tbl[1]  = mk(0, 0, 0,      0, 0, 0,            0, 0, 0, 0,  0, 0,  0, 0, 0,            0, 0, 32'h0);
        tbl[2]  = mk(1, 3, 32'h11, 1, 6, 32'h66,       0, 0, 0, 0,  0, 0,  1, 3, 32'h11,       0, 0, 32'h0);
        tbl[3]  = mk(0, 0, 0,      1, 6, 32'h66,       0, 0, 0, 0,  1, 0,  1, 6, 32'h66,       0, 0, 32'h0);
        tbl[4]  = mk(0, 0, 0,      0, 0, 0,            0, 0, 0, 0,  0, 0,  0, 0, 0,            0, 0, 32'h0);
        tbl[5]  = mk(0, 0, 0,      0, 0, 0,            1, 7, 7, 0,  0, 0,  0, 0, 0,            0, 0, 32'h80);
        tbl[6]  = mk(0, 0, 0,      0, 0, 0,            0, 0, 7, 0,  0, 1,  0, 0, 0,            0, 0, 32'h80);
        tbl[7]  = mk(0, 0, 0,      1, 7, 32'h77,       0, 0, 0, 7,  1, 1,  1, 7, 32'h77,       0, 0, 32'h0);
        tbl[8]  = mk(0, 0, 0,      0, 0, 0,            0, 0, 7, 0,  0, 0,  0, 0, 0,            0, 0, 32'h0);
        tbl[9]  = mk(0, 0, 0,      1, 9, 32'h99,       1, 9, 0, 0,  1, 0,  1, 9, 32'h99,       0, 0, 32'h200);
        tbl[10] = mk(0, 0, 0,      0, 0, 0,            0, 0, 9, 0,  0, 1,  0, 0, 0,            0, 0, 32'h200);
        tbl[11] = mk(0, 0, 0,      1, 9, 32'h9A,       0, 0, 0, 0,  1, 0,  1, 9, 32'h9A,       0, 0, 32'h0);
        tbl[12] = mk(0, 0, 0,      1, 0, 32'h1234,     0, 0, 0, 0,  1, 0,  0, 0, 0,            0, 0, 32'h0);
        tbl[13] = mk(0, 0, 0,      0, 0, 0,            1, 0, 0, 0,  0, 0,  0, 0, 0,            0, 0, 32'h0);

        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset");

        for (int i = 0; i < 14; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Starvation, WB backs off during hold: MDU gets the slot, no error.
        for (int i = 0; i < 4; i++) begin
            run_vec($sformatf("starveA%0d", i),
                    mk(1, 1, 32'hA0 + 32'(i), 1, 2, 32'h22, 0, 0, 0, 0,
                       0, 0, 1, 1, 32'hA0 + 32'(i), (i == 3), 0, 32'h0));
        end
        run_vec("starveA_hold", mk(0, 0, 0, 1, 2, 32'h22, 0, 0, 0, 0,
                                   1, 0, 1, 2, 32'h22, 0, 0, 32'h0));
        run_vec("starveA_idle", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                                   0, 0, 0, 0, 0, 0, 0, 32'h0));

        // Mid-operation reset: busy[7] pending and counter at 3.
        run_vec("midrst_set", mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 0,
                                 0, 0, 0, 0, 0, 0, 0, 32'h80));
        for (int i = 0; i < 3; i++) begin
            run_vec($sformatf("midrst_refuse%0d", i),
                    mk(1, 1, 32'hB0, 1, 2, 32'h22, 0, 0, 0, 0,
                       0, 0, 1, 1, 32'hB0, 0, 0, 32'h80));
        end
        do_reset("midrst");

        // Starvation, WB ignores hold: error flagged, WB still wins. Hold must
        // appear only after four refusals, proving the counter was cleared.
        for (int i = 0; i < 4; i++) begin
            run_vec($sformatf("starveB%0d", i),
                    mk(1, 1, 32'hC0 + 32'(i), 1, 2, 32'h23, 0, 0, 0, 0,
                       0, 0, 1, 1, 32'hC0 + 32'(i), (i == 3), 0, 32'h0));
        end
        run_vec("starveB_hold", mk(1, 1, 32'hCC, 1, 2, 32'h23, 0, 0, 0, 0,
                                   0, 0, 1, 1, 32'hCC, 0, 1, 32'h0));
        run_vec("starveB_drain", mk(0, 0, 0, 1, 2, 32'h23, 0, 0, 0, 0,
                                    1, 0, 1, 2, 32'h23, 0, 1, 32'h0));
        run_vec("starveB_sticky", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                                     0, 0, 0, 0, 0, 0, 1, 32'h0));

        // WAW guard: WB write to a pending register flags err but still writes.
        do_reset("wawrst");
        run_vec("waw_set", mk(0, 0, 0, 0, 0, 0, 1, 4, 0, 0,
                              0, 0, 0, 0, 0, 0, 0, 32'h10));
        run_vec("waw_write", mk(1, 4, 32'h44, 0, 0, 0, 0, 0, 4, 0,
                                0, 1, 1, 4, 32'h44, 0, 1, 32'h10));
        run_vec("waw_sticky", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                                 0, 0, 0, 0, 0, 0, 1, 32'h10));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
